// File: rtl/match_controller_pkg.sv
// Shared definitions for the match controller and the score display.
// Holds the state encoding (also exported on o_state) and the default score
// geometry, so the display decodes states and sizes score digits identically.
package match_controller_pkg;

  // Default match length and score counter width.
  localparam int unsigned DefaultWinScore = 9;
  localparam int unsigned DefaultScoreW   = 4;

  // 3-bit state encoding; codes 6 and 7 are unused and recover to StIdle.
  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StServeLeft  = 3'd1,
    StServeRight = 3'd2,
    StRally      = 3'd3,
    StPointPause = 3'd4,
    StGameOver   = 3'd5
  } state_e;

endpackage

// File: rtl/match_controller_tick.sv
// tick_timer: clearable counter of frame strobes with a terminal-count compare.
// Ports:
//   i_clock, i_reset : clock and asynchronous active-high reset
//   i_clear          : synchronous clear (has priority over i_enable)
//   i_enable         : count one strobe this cycle
//   i_limit          : terminal count to compare against
//   o_done           : high while the count equals i_limit
module tick_timer #(
  parameter int unsigned TICK_W = 9
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic [TICK_W-1:0] i_limit,
  output logic              o_done
);

  logic [TICK_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + TICK_W'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_done = (count_q == i_limit);

endmodule

// File: rtl/match_controller.sv
// match_controller: sequences a full match - serve grant, launch, scoring,
// post-point pause and game-over hold-off - around the ball/paddle datapath.
// Ports:
//   i_clock, i_reset           : clock, asynchronous active-high reset
//   i_tick                     : one-cycle frame strobe, the only time base
//   i_left_click/i_right_click : serve buttons (debounced single-cycle pulses)
//   i_left_miss/i_right_miss   : ball passed a paddle (single-cycle pulses)
//   o_serve_left/o_serve_right : side currently holding the serve
//   o_ball_in_game             : high in RALLY
//   o_launch                   : one-cycle pulse on the first RALLY cycle
//   o_left_score/o_right_score : player points
//   o_game_over, o_winner      : match finished; winner 0 = left, 1 = right
//   o_state                    : current state encoding
module match_controller
  import match_controller_pkg::*;
#(
  parameter int unsigned WIN_SCORE     = DefaultWinScore,
  parameter int unsigned SCORE_W       = DefaultScoreW,
  parameter int unsigned PAUSE_TICKS   = 60,
  parameter int unsigned SERVE_TIMEOUT = 300,
  parameter int unsigned TICK_W        = 9
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_left_click,
  input  logic               i_right_click,
  input  logic               i_left_miss,
  input  logic               i_right_miss,
  output logic               o_serve_left,
  output logic               o_serve_right,
  output logic               o_ball_in_game,
  output logic               o_launch,
  output logic [SCORE_W-1:0] o_left_score,
  output logic [SCORE_W-1:0] o_right_score,
  output logic               o_game_over,
  output logic               o_winner,
  output logic [2:0]         o_state
);

  localparam logic [SCORE_W-1:0] WinScore  = SCORE_W'(WIN_SCORE);
  localparam logic [TICK_W-1:0]  ServeLast = TICK_W'(SERVE_TIMEOUT - 1);
  localparam logic [TICK_W-1:0]  PauseLast = TICK_W'(PAUSE_TICKS - 1);
  // Game-over count stops here, marking the hold-off as fully elapsed.
  localparam logic [TICK_W-1:0]  PauseFull = TICK_W'(PAUSE_TICKS);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] left_score_q, left_score_d;
  logic [SCORE_W-1:0] right_score_q, right_score_d;
  logic               server_q, server_d;   // pending server: 0 = left, 1 = right
  logic               winner_q, winner_d;
  logic               launch_q, launch_d;

  logic               timer_clear;
  logic               timer_enable;
  logic [TICK_W-1:0]  timer_limit;
  logic               timer_done;
  logic [SCORE_W-1:0] left_inc, right_inc;
  logic               any_click;

  assign left_inc  = left_score_q + SCORE_W'(1);
  assign right_inc = right_score_q + SCORE_W'(1);
  assign any_click = i_left_click | i_right_click;

  tick_timer #(
    .TICK_W (TICK_W)
  ) u_tick_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (timer_clear),
    .i_enable (timer_enable),
    .i_limit  (timer_limit),
    .o_done   (timer_done)
  );

  always_comb begin
    state_d       = state_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    server_d      = server_q;
    winner_d      = winner_q;
    timer_enable  = 1'b0;
    timer_limit   = PauseLast;

    case (state_q)
      StIdle: begin
        state_d       = StServeLeft;
        left_score_d  = '0;
        right_score_d = '0;
      end
      StServeLeft: begin
        timer_limit  = ServeLast;
        timer_enable = i_tick;
        if (i_left_click || (i_tick && timer_done)) begin
          state_d = StRally;
        end
      end
      StServeRight: begin
        timer_limit  = ServeLast;
        timer_enable = i_tick;
        if (i_right_click || (i_tick && timer_done)) begin
          state_d = StRally;
        end
      end
      StRally: begin
        // Left miss wins when both sides miss in the same cycle.
        if (i_left_miss) begin
          right_score_d = right_inc;
          server_d      = 1'b1;
          if (right_inc == WinScore) begin
            state_d  = StGameOver;
            winner_d = 1'b1;
          end else begin
            state_d = StPointPause;
          end
        end else if (i_right_miss) begin
          left_score_d = left_inc;
          server_d     = 1'b0;
          if (left_inc == WinScore) begin
            state_d  = StGameOver;
            winner_d = 1'b0;
          end else begin
            state_d = StPointPause;
          end
        end
      end
      StPointPause: begin
        timer_enable = i_tick;
        if (i_tick && timer_done) begin
          state_d = server_q ? StServeRight : StServeLeft;
        end
      end
      StGameOver: begin
        // Saturate once the hold-off has elapsed; only then accept a click.
        timer_limit  = PauseFull;
        timer_enable = i_tick && !timer_done;
        if (timer_done && any_click) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign timer_clear = (state_d != state_q);
  assign launch_d    = (state_d == StRally) && (state_q != StRally);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= StIdle;
      left_score_q  <= '0;
      right_score_q <= '0;
      server_q      <= 1'b0;
      winner_q      <= 1'b0;
      launch_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      server_q      <= server_d;
      winner_q      <= winner_d;
      launch_q      <= launch_d;
    end
  end

  assign o_serve_left   = (state_q == StServeLeft);
  assign o_serve_right  = (state_q == StServeRight);
  assign o_ball_in_game = (state_q == StRally);
  assign o_game_over    = (state_q == StGameOver);
  assign o_launch       = launch_q;
  assign o_left_score   = left_score_q;
  assign o_right_score  = right_score_q;
  assign o_winner       = winner_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_match_controller.sv
module tb_match_controller;

  localparam int WIN   = 9;
  localparam int SW    = 4;
  localparam int PAUSE = 60;
  localparam int SERVE = 300;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0, lc = 1'b0, rc = 1'b0, lm = 1'b0, rm = 1'b0;
  logic serve_left, serve_right, ball_in_game, launch, game_over, winner;
  logic [SW-1:0] left_score, right_score;
  logic [2:0] state;

  always #5 clock = ~clock;

  match_controller #(
    .WIN_SCORE     (WIN),
    .SCORE_W       (SW),
    .PAUSE_TICKS   (PAUSE),
    .SERVE_TIMEOUT (SERVE),
    .TICK_W        (9)
  ) dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_tick         (tick),
    .i_left_click   (lc),
    .i_right_click  (rc),
    .i_left_miss    (lm),
    .i_right_miss   (rm),
    .o_serve_left   (serve_left),
    .o_serve_right  (serve_right),
    .o_ball_in_game (ball_in_game),
    .o_launch       (launch),
    .o_left_score   (left_score),
    .o_right_score  (right_score),
    .o_game_over    (game_over),
    .o_winner       (winner),
    .o_state        (state)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: match phase as a plain integer, ticks seen in the phase.
  int m_state, m_l, m_r, m_ticks, m_server, m_winner, m_launch;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic model_reset();
    m_state = 0; m_l = 0; m_r = 0; m_ticks = 0;
    m_server = 0; m_winner = 0; m_launch = 0;
  endtask

  task automatic model_step(input bit t, input bit l_click, input bit r_click,
                            input bit l_miss, input bit r_miss);
    int nxt;
    nxt = m_state;
    case (m_state)
      0: begin nxt = 1; m_l = 0; m_r = 0; end
      1, 2: begin
        if ((m_state == 1 && l_click) || (m_state == 2 && r_click)) nxt = 3;
        else if (t) begin
          m_ticks++;
          if (m_ticks == SERVE) nxt = 3;
        end
      end
      3: begin
        if (l_miss) begin
          m_r++; m_server = 1;
          if (m_r == WIN) begin nxt = 5; m_winner = 1; end else nxt = 4;
        end else if (r_miss) begin
          m_l++; m_server = 0;
          if (m_l == WIN) begin nxt = 5; m_winner = 0; end else nxt = 4;
        end
      end
      4: if (t) begin
        m_ticks++;
        if (m_ticks == PAUSE) nxt = (m_server == 1) ? 2 : 1;
      end
      5: begin
        if (m_ticks >= PAUSE && (l_click || r_click)) nxt = 0;
        else if (t && m_ticks < PAUSE) m_ticks++;
      end
      default: nxt = 0;
    endcase
    m_launch = (nxt == 3 && m_state != 3) ? 1 : 0;
    if (nxt != m_state) m_ticks = 0;
    m_state = nxt;
  endtask

  task automatic compare_model();
    int exp_flags, act_flags;
    exp_flags = {27'd0, m_state == 1, m_state == 2, m_state == 3, m_state == 5, m_launch[0]};
    act_flags = {27'd0, serve_left, serve_right, ball_in_game, game_over, launch};
    check("state", int'(state), m_state);
    check("left_score", int'(left_score), m_l);
    check("right_score", int'(right_score), m_r);
    check("flags{sl,sr,ball,go,launch}", act_flags, exp_flags);
    if (m_state == 5) check("winner", int'(winner), m_winner);
  endtask

  task automatic cycle(input bit t, input bit l_click, input bit r_click,
                       input bit l_miss, input bit r_miss);
    tick = t; lc = l_click; rc = r_click; lm = l_miss; rm = r_miss;
    @(posedge clock);
    model_step(t, l_click, r_click, l_miss, r_miss);
    #1;
    tick = 0; lc = 0; rc = 0; lm = 0; rm = 0;
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
  endtask

  // Serve from whichever side holds it, then award a point.
  task automatic score_point(input bit left_scores, input bit wait_pause);
    if (m_state == 1) cycle(0, 1, 0, 0, 0);
    else if (m_state == 2) cycle(0, 0, 1, 0, 0);
    check("serve_launch", int'(launch), 1);
    cycle(0, 0, 0, !left_scores, left_scores);
    if (wait_pause && m_state == 4) ticks(PAUSE);
  endtask

  typedef struct {
    bit t, l_click, r_click, l_miss, r_miss;
    int st, ls, rs;
    bit launch;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};  // IDLE -> SERVE_LEFT
    vecs[1] = '{0, 1, 0, 0, 0, 3, 0, 0, 1};  // left click launches
    vecs[2] = '{0, 0, 0, 0, 0, 3, 0, 0, 0};  // launch is one cycle
    vecs[3] = '{0, 0, 0, 1, 0, 4, 0, 1, 0};  // left miss: right scores
    vecs[4] = '{0, 1, 0, 0, 0, 4, 0, 1, 0};  // click in pause ignored
    vecs[5] = '{1, 0, 1, 0, 0, 4, 0, 1, 0};  // tick 1 of pause, click ignored
    vecs[6] = '{0, 0, 0, 1, 0, 4, 0, 1, 0};  // miss outside rally ignored

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare_model();
    reset = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].t, vecs[i].l_click, vecs[i].r_click, vecs[i].l_miss, vecs[i].r_miss);
      check("vec_state", int'(state), vecs[i].st);
      check("vec_left", int'(left_score), vecs[i].ls);
      check("vec_right", int'(right_score), vecs[i].rs);
      check("vec_launch", int'(launch), int'(vecs[i].launch));
    end

    // Pause lasts exactly 60 ticks, then right serves.
    ticks(PAUSE - 2);
    check("pause_hold", int'(state), 4);
    ticks(1);
    check("pause_to_serve_right", int'(state), 2);
    check("serve_right_out", int'(serve_right), 1);

    // Auto-serve after 300 ticks with idle cycles interleaved.
    cycle(0, 0, 0, 0, 0);
    ticks(SERVE - 1);
    check("serve_hold", int'(state), 2);
    ticks(1);
    check("auto_launch_state", int'(state), 3);
    check("auto_launch_pulse", int'(launch), 1);
    cycle(0, 0, 0, 0, 0);
    check("auto_launch_once", int'(launch), 0);

    // Simultaneous misses: left miss only.
    cycle(0, 0, 0, 1, 1);
    check("both_miss_right", int'(right_score), 2);
    check("both_miss_left", int'(left_score), 0);
    ticks(PAUSE);
    check("both_miss_server", int'(state), 2);

    // Click and tick together in serve: click wins.
    cycle(1, 0, 1, 0, 0);
    check("click_tick_launch", int'(launch), 1);

    // Left plays to 9.
    for (int k = 1; k <= WIN; k++) begin
      cycle(0, 0, 0, 0, 1);
      check("left_points", int'(left_score), k);
      if (k < WIN) begin
        ticks(PAUSE);
        cycle(0, 1, 0, 0, 0);
      end
    end
    check("game_over", int'(game_over), 1);
    check("winner_left", int'(winner), 0);
    ticks(PAUSE - 1);
    cycle(0, 1, 0, 0, 0);
    check("early_click_ignored", int'(state), 5);
    ticks(6);
    cycle(0, 0, 1, 0, 0);
    check("click_to_idle", int'(state), 0);
    check("idle_scores_held", int'(left_score), WIN);
    cycle(0, 0, 0, 0, 0);
    check("new_match_state", int'(state), 1);
    check("new_match_left", int'(left_score), 0);
    check("new_match_right", int'(right_score), 0);

    // Build 3/5 and abort mid-pause with an asynchronous reset.
    for (int i = 0; i < 3; i++) score_point(1, 1);
    for (int i = 0; i < 5; i++) score_point(0, i < 4);
    ticks(10);
    check("pre_reset_state", int'(state), 4);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_model();
    check("reset_winner", int'(winner), 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Randomized play against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Sequences a full match of play around the ball/paddle datapath: grants serves, launches the ball, keeps score, inserts post-point pauses and declares the winner.
- Sits between the paddle/button inputs, the ball engine (miss detection) and the score display.
- Adds scoring, auto-serve timeout, inter-point pause and game-over handling on top of the basic serve/rally sequencing.

Parameters:
- WIN_SCORE, 9, points needed to win; legal range 1..(2^SCORE_W - 1).
- SCORE_W, 4, width of each score counter.
- PAUSE_TICKS, 60, number of i_tick strobes held in POINT_PAUSE and in the GAME_OVER hold-off; minimum 1.
- SERVE_TIMEOUT, 300, number of i_tick strobes in a serve state before an automatic launch; minimum 1.
- TICK_W, 9, width of the tick counter; must hold max(PAUSE_TICKS, SERVE_TIMEOUT).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_tick  in  1  one-cycle frame strobe (for example 60 Hz); the only time base.
- i_left_click  in  1  left serve button; single-cycle pulse, already debounced.
- i_right_click  in  1  right serve button; single-cycle pulse.
- i_left_miss  in  1  ball passed the left paddle; single-cycle pulse.
- i_right_miss  in  1  ball passed the right paddle; single-cycle pulse.
- o_serve_left  out  1  high while the left side holds the serve.
- o_serve_right  out  1  high while the right side holds the serve.
- o_ball_in_game  out  1  high in RALLY.
- o_launch  out  1  one-cycle pulse on the cycle RALLY is entered.
- o_left_score  out  SCORE_W  left player points.
- o_right_score  out  SCORE_W  right player points.
- o_game_over  out  1  high in GAME_OVER.
- o_winner  out  1  0 = left won, 1 = right won; valid while o_game_over is high.
- o_state  out  3  current state encoding, for debug and the display.

Behaviour:
- State encodings: IDLE=0, SERVE_LEFT=1, SERVE_RIGHT=2, RALLY=3, POINT_PAUSE=4, GAME_OVER=5. Codes 6 and 7 recover to IDLE on the next clock.
- Reset (asynchronous):
  - state = IDLE; both scores = 0; tick counter = 0; pending server = left; o_winner = 0.
  - All single-bit outputs are 0.
  - Reset asserted mid-rally or mid-pause aborts immediately; no launch pulse is produced.
- Tick counter:
  - Cleared on every state change.
  - Increments on i_tick only in SERVE_*, POINT_PAUSE and GAME_OVER.
- IDLE:
  - Next cycle goes unconditionally to SERVE_LEFT.
  - Scores are cleared on this transition.
- SERVE_LEFT:
  - i_left_click goes to RALLY.
  - Otherwise, when the tick counter reaches SERVE_TIMEOUT-1 and i_tick is high, goes to RALLY (auto-serve).
  - i_right_click is ignored.
- SERVE_RIGHT: mirror of SERVE_LEFT.
- Misses and clicks outside RALLY are ignored.
- Launch and outputs:
  - o_launch is registered: high exactly the one cycle after the transition, i.e. the first cycle o_state == RALLY.
  - o_serve_*, o_ball_in_game and o_game_over are decoded from the registered state, so they are Moore outputs with no combinational path from inputs.
- RALLY:
  - i_left_miss: right score += 1 and pending server = right.
  - Else i_right_miss: left score += 1 and pending server = left.
  - Both misses in the same cycle: treated as i_left_miss only (left has priority).
  - The score register updates on the same edge as the state change.
- Point outcome from RALLY:
  - If the incremented score equals WIN_SCORE: go to GAME_OVER, with o_winner = the side that scored.
  - Otherwise go to POINT_PAUSE.
- Scoring is never evaluated outside RALLY, so a score cannot exceed WIN_SCORE.
- POINT_PAUSE:
  - All clicks are ignored.
  - After PAUSE_TICKS ticks (counter reaches PAUSE_TICKS-1 with i_tick high), go to SERVE_<pending server>.
- GAME_OVER:
  - Scores and o_winner are held.
  - Clicks are ignored until PAUSE_TICKS ticks have elapsed (the counter saturates).
  - After that, any click goes to IDLE, which then clears the scores and starts a new match with a left serve.
- A click and i_tick arriving in the same cycle while in a serve state: the click wins and the tick is irrelevant.

Decomposition:
- Shared package holds:
  - the state encoding constants (3-bit);
  - the WIN_SCORE and SCORE_W defaults, so the score display uses the same widths.
- One sub-module: tick_timer.
  - Clearable counter of i_tick strobes with a terminal-count compare output.
  - Instantiated once and shared by the serve, pause and game-over states.

Test Plan:
- Release reset, then press i_left_click with no ticks: o_state goes 0 -> 1 -> 3; o_launch pulses on the first RALLY cycle; scores stay 0/0.
- In RALLY, pulse i_left_miss: o_right_score = 1; state = 4 for exactly 60 ticks, then state = 2 (SERVE_RIGHT). i_left_click during the pause has no effect.
- In SERVE_RIGHT, apply no clicks: after 300 ticks, auto-launch; o_launch pulses once; state = 3.
- In RALLY, pulse i_left_miss and i_right_miss in the same cycle: right score +1 only; next server = right.
- Play left to 9 points: o_game_over = 1 and o_winner = 0. A click before 60 ticks is ignored; a click after 60 ticks gives IDLE, then scores 0/0, then SERVE_LEFT.
- Assert i_reset mid-POINT_PAUSE with score 3/5: all outputs are 0 and the state is IDLE immediately (asynchronously).
